vga_timing_gen: RTL
===================

// Module: vga_timing_gen
// PURPOSE
//   Parametrised VGA raster timing generator; successor to vga_driver. Generates
//   pixel-enable, col/row position, display window, sync and frame/line markers.
//   Configurable timing, sync polarity and clock divider; adds a run/freeze enable.
//   Sits between the system clock and the pixel source / video DAC pins.
// PARAMETERS
//   H_ACTIVE  640  visible pixels per line
//   H_FP      16   horizontal front porch, pixels
//   H_SYNC    96   horizontal sync width, pixels
//   H_BP      48   horizontal back porch, pixels
//   V_ACTIVE  480  visible lines per frame
//   V_FP      10   vertical front porch, lines
//   V_SYNC    2    vertical sync width, lines
//   V_BP      33   vertical back porch, lines
//   PIX_DIV   2    clk cycles per pixel (>=1); 50 MHz clk -> 25 MHz pixel rate
//   HS_POL    0    hsync asserted level (0 = active-low)
//   VS_POL    0    vsync asserted level (0 = active-low)
//   COL_W     10   vga_col width; H_TOTAL must be <= 2**COL_W
//   ROW_W     9    vga_row width; V_ACTIVE must be <= 2**ROW_W
// PORTS
//   clk          in   1      system clock
//   rst_l        in   1      asynchronous reset, active-low
//   en           in   1      1 = run; 0 = freeze prescaler, counters and outputs
//   pix_ce       out  1      1-clk strobe, one per pixel period
//   vga_col      out  COL_W  current column, 0 outside active region
//   vga_row      out  ROW_W  current row, 0 outside active region
//   vga_display  out  1      1 when current pixel is inside active window
//   vga_hs       out  1      hsync at HS_POL when asserted
//   vga_vs       out  1      vsync at VS_POL when asserted
//   line_start   out  1      1-clk pulse at pixel (h=0) of every line
//   frame_start  out  1      1-clk pulse at pixel (0,0) of every frame
//   vblank       out  1      1 while v >= V_ACTIVE
// BEHAVIOUR
//   - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Internal h 0..H_TOTAL-1, v 0..V_TOTAL-1.
//   - Reset (rst_l=0, async, also mid-frame): prescaler=0, h=v=0, pix_ce=0, col=row=0,
//     display=0, line_start=frame_start=0, vblank=0, vga_hs=~HS_POL, vga_vs=~VS_POL.
//   - Prescaler counts 0..PIX_DIV-1 while en=1; pix_ce=1 for the clk in which it equals
//     PIX_DIV-1 (PIX_DIV=1: pix_ce=1 every enabled clk). First pix_ce: PIX_DIV-th clk after release.
//   - On each pix_ce clk: outputs registered from current (h,v), then h advances.
//     Result visible the clk after pix_ce; held until the next pix_ce update.
//   - h wraps H_TOTAL-1 -> 0 and increments v; v wraps V_TOTAL-1 -> 0 in same tick.
//   - display = (h<H_ACTIVE)&&(v<V_ACTIVE); col=h, row=v when display else 0.
//   - hsync asserted for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC; vsync asserted for
//     V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, on whole lines (h-independent).
//   - line_start (h==0) and frame_start (h==0&&v==0) high exactly 1 clk per occurrence.
//   - en=0: prescaler, h, v and all level outputs hold; pix_ce, line_start, frame_start
//     forced 0. en=1 resumes at the held prescaler phase with no skipped pixel.
//   - Widths: h needs clog2(H_TOTAL) bits, v clog2(V_TOTAL); col/row truncate to COL_W/ROW_W.
//   - Elaboration error if PIX_DIV<1 or any porch/sync/active parameter is 0.
// TESTING
//   1 Reset release, defaults, en=1: first pix_ce at clk 2; clk 3 shows col=0,row=0,
//     display=1, line_start=1, frame_start=1, vga_hs=1, vga_vs=1.
//   2 Defaults: vga_hs low exactly 96 px (192 clk) per line, falling edge 656 px after
//     line_start; line period 800 px = 1600 clk.
//   3 Full frame: frame_start period 420000 px = 840000 clk; vga_vs low 2 lines from
//     line 490; vblank=1 lines 480..524; display count per frame = 307200 px.
//   4 PIX_DIV=1, HS_POL=1, VS_POL=1: pix_ce constant 1; hsync/vsync high-true with same
//     widths; col sweeps 0..639 on consecutive clks.
//   5 en=0 for 37 clk mid-line at col=100: pix_ce=0, col holds 100; after en=1 next
//     pixel is col=101 (no skip, no repeat).
//   6 rst_l=0 mid-frame (row 300): outputs go to reset values without clk edge;
//     after release frame restarts at (0,0) with frame_start.

Source files
------------

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA raster timing generator
// Produces pixel strobe, active-window position, syncs and line/frame markers with run/freeze.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int PIX_DIV  = 2,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int COL_W    = 10,
    parameter int ROW_W    = 9
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             en,
    output logic             pix_ce,
    output logic [COL_W-1:0] vga_col,
    output logic [ROW_W-1:0] vga_row,
    output logic             vga_display,
    output logic             vga_hs,
    output logic             vga_vs,
    output logic             line_start,
    output logic             frame_start,
    output logic             vblank
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_W     = $clog2(H_TOTAL);
    localparam int V_W     = $clog2(V_TOTAL);
    localparam int PRE_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST     = PRE_W'(PIX_DIV - 1);
    localparam logic [H_W-1:0]   H_LAST       = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0]   H_ACT_END    = H_W'(H_ACTIVE);
    localparam logic [H_W-1:0]   H_SYNC_START = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0]   H_SYNC_END   = H_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [V_W-1:0]   V_LAST       = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0]   V_ACT_END    = V_W'(V_ACTIVE);
    localparam logic [V_W-1:0]   V_SYNC_START = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0]   V_SYNC_END   = V_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic             HS_ON        = (HS_POL != 0);
    localparam logic             VS_ON        = (VS_POL != 0);

    if (PIX_DIV < 1 || H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_param
        $error("vga_timing_gen: PIX_DIV and all active/porch/sync parameters must be >= 1");
    end

    logic [PRE_W-1:0] r_pre;
    logic             r_pix_ce;
    logic [H_W-1:0]   r_h;
    logic [V_W-1:0]   r_v;
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic             r_disp;
    logic             r_hs;
    logic             r_vs;
    logic             r_vblank;
    logic             r_ls;
    logic             r_fs;

    logic w_pre_last;
    logic w_h_last;
    logic w_v_last;
    logic w_disp;
    logic w_hs_on;
    logic w_vs_on;
    logic w_advance;

    assign w_pre_last = (r_pre == PRE_LAST);
    assign w_h_last   = (r_h == H_LAST);
    assign w_v_last   = (r_v == V_LAST);
    assign w_disp     = (r_h < H_ACT_END) && (r_v < V_ACT_END);
    assign w_hs_on    = (r_h >= H_SYNC_START) && (r_h < H_SYNC_END);
    assign w_vs_on    = (r_v >= V_SYNC_START) && (r_v < V_SYNC_END);
    assign w_advance  = en && r_pix_ce;

    // The strobe is registered so it stays low through reset even when PIX_DIV=1.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_pre    <= '0;
            r_pix_ce <= 1'b0;
        end else if (en) begin
            r_pre    <= w_pre_last ? '0 : r_pre + 1'b1;
            r_pix_ce <= w_pre_last;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_h      <= '0;
            r_v      <= '0;
            r_col    <= '0;
            r_row    <= '0;
            r_disp   <= 1'b0;
            r_hs     <= ~HS_ON;
            r_vs     <= ~VS_ON;
            r_vblank <= 1'b0;
        end else if (w_advance) begin
            r_col    <= w_disp ? COL_W'(r_h) : '0;
            r_row    <= w_disp ? ROW_W'(r_v) : '0;
            r_disp   <= w_disp;
            r_hs     <= w_hs_on ? HS_ON : ~HS_ON;
            r_vs     <= w_vs_on ? VS_ON : ~VS_ON;
            r_vblank <= (r_v >= V_ACT_END);
            if (w_h_last) begin
                r_h <= '0;
                r_v <= w_v_last ? '0 : r_v + 1'b1;
            end else begin
                r_h <= r_h + 1'b1;
            end
        end
    end

    // Markers are held (not cleared) while frozen so a pending pulse survives en=0.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_ls <= 1'b0;
            r_fs <= 1'b0;
        end else if (en) begin
            r_ls <= r_pix_ce && (r_h == '0);
            r_fs <= r_pix_ce && (r_h == '0) && (r_v == '0);
        end
    end

    assign pix_ce      = r_pix_ce && en;
    assign line_start  = r_ls && en;
    assign frame_start = r_fs && en;
    assign vga_col     = r_col;
    assign vga_row     = r_row;
    assign vga_display = r_disp;
    assign vga_hs      = r_hs;
    assign vga_vs      = r_vs;
    assign vblank      = r_vblank;

endmodule
